// File: rtl/register_mode_pkg.sv
// rtl/register_mode_pkg.sv - mode encoding and sizing helpers shared by the register-mode pipe
package register_mode_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_CONST  = 2'd0,
        MODE_DELAY  = 2'd1,
        MODE_BYPASS = 2'd2,
        MODE_PIPE   = 2'd3
    } mode_t;

    // A single-stage pipe still needs a one-bit address port.
    function automatic int addr_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/register_mode_stage.sv
// rtl/register_mode_stage.sv - one data+valid stage; priority load > clr_valid > shift
module register_mode_stage #(
    parameter int              WIDTH = 16,
    parameter logic [WIDTH-1:0] INIT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] shift_data,
    input  logic             shift_valid,
    input  logic             clr_valid,
    output logic [WIDTH-1:0] data_q,
    output logic             valid_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= INIT;
            valid_q <= 1'b0;
        end else if (load) begin
            data_q  <= load_data;
            valid_q <= 1'b1;
        end else if (clr_valid) begin
            valid_q <= 1'b0;
        end else if (shift_en) begin
            data_q  <= shift_data;
            valid_q <= shift_valid;
        end
    end

endmodule

// File: rtl/register_mode_pipe.sv
// rtl/register_mode_pipe.sv - const/bypass/delay/pipe register block; optional fill port under REGISTER_MODE_PIPE_FILL_EN
module register_mode_pipe
    import register_mode_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter int               DEPTH = 4,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic                            CLK,
    input  logic                            ASYNCRESETN,
    input  logic [MODE_W-1:0]               mode,
    input  logic [WIDTH-1:0]                const_,
    input  logic [WIDTH-1:0]                value,
    input  logic                            value_valid,
    input  logic                            clk_en,
    input  logic                            flush,
    input  logic                            config_we,
    input  logic [addr_width(DEPTH)-1:0]    config_addr,
    input  logic [WIDTH-1:0]                config_data,
    output logic [WIDTH-1:0]                config_rdata,
    output logic [WIDTH-1:0]                O0,
    output logic [WIDTH-1:0]                O1,
`ifdef REGISTER_MODE_PIPE_FILL_EN
    output logic [$clog2(DEPTH+1)-1:0]      fill,
`endif
    output logic                            out_valid
);

    mode_t mode_e;
    logic  cfg_hit;
    logic  adv;

    logic [WIDTH-1:0] s   [DEPTH];
    logic [WIDTH-1:0] shd [DEPTH];
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] ld;
    logic [DEPTH-1:0] sh;
    logic [DEPTH-1:0] shv;

    assign mode_e  = mode_t'(mode);
    assign cfg_hit = config_we && (32'(config_addr) < DEPTH);

    // A config write or flush freezes the shift for the whole chain that cycle.
    assign adv = clk_en && !cfg_hit && !flush &&
                 ((mode_e == MODE_DELAY) || (mode_e == MODE_PIPE));

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign sh[i]  = adv;
            assign shd[i] = value;
            assign shv[i] = value_valid;
        end else begin : g_body
            assign sh[i]  = adv && (mode_e == MODE_PIPE);
            assign shd[i] = s[i-1];
            assign shv[i] = v[i-1];
        end

        assign ld[i] = cfg_hit && (32'(config_addr) == i);

        register_mode_stage #(
            .WIDTH (WIDTH),
            .INIT  (INIT)
        ) u_stage (
            .clk         (CLK),
            .rst_n       (ASYNCRESETN),
            .load        (ld[i]),
            .load_data   (config_data),
            .shift_en    (sh[i]),
            .shift_data  (shd[i]),
            .shift_valid (shv[i]),
            .clr_valid   (flush),
            .data_q      (s[i]),
            .valid_q     (v[i])
        );
    end

    always_comb begin
        O0        = s[DEPTH-1];
        out_valid = v[DEPTH-1];
        case (mode_e)
            MODE_CONST: begin
                O0        = const_;
                out_valid = 1'b1;
            end
            MODE_BYPASS: begin
                O0        = value;
                out_valid = value_valid;
            end
            MODE_DELAY: begin
                O0        = s[0];
                out_valid = v[0];
            end
            default: begin
                O0        = s[DEPTH-1];
                out_valid = v[DEPTH-1];
            end
        endcase
    end

    // Out-of-range addresses read as zero rather than aliasing onto a stage.
    always_comb begin
        config_rdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (32'(config_addr) == i) begin
                config_rdata = s[i];
            end
        end
    end

    assign O1 = s[0];

`ifdef REGISTER_MODE_PIPE_FILL_EN
    localparam int FW = $clog2(DEPTH+1);

    logic [FW-1:0] fill_q;
    logic [FW-1:0] fill_d;

    // Popcount of the next-state valid vector, mirroring the stage priority.
    always_comb begin
        fill_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ld[i] || (!flush && (sh[i] ? shv[i] : v[i]))) begin
                fill_d = fill_d + FW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end

    assign fill = fill_q;
`endif

endmodule

// File: tb/tb_register_mode_pipe.sv
// tb/tb_register_mode_pipe.sv - directed self-checking bench for register_mode_pipe
module tb_register_mode_pipe;

    logic        CLK = 1'b0;
    logic        ASYNCRESETN = 1'b0;
    logic [1:0]  mode = 2'd3;
    logic [15:0] const_ = '0;
    logic [15:0] value = '0;
    logic        value_valid = 1'b0;
    logic        clk_en = 1'b0;
    logic        flush = 1'b0;
    logic        config_we = 1'b0;
    logic [1:0]  config_addr = '0;
    logic [15:0] config_data = '0;
    logic [15:0] config_rdata, O0, O1;
    logic        out_valid;

    logic        we_b = 1'b0;
    logic [2:0]  addr_b = '0;
    logic [15:0] rdata_b, O0_b, O1_b;
    logic        out_valid_b;

`ifdef REGISTER_MODE_PIPE_FILL_EN
    logic [2:0]  fill;
    logic [2:0]  fill_b;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    register_mode_pipe #(.WIDTH(16), .DEPTH(4), .INIT(16'h0000)) dut (
        .CLK          (CLK),
        .ASYNCRESETN  (ASYNCRESETN),
        .mode         (mode),
        .const_       (const_),
        .value        (value),
        .value_valid  (value_valid),
        .clk_en       (clk_en),
        .flush        (flush),
        .config_we    (config_we),
        .config_addr  (config_addr),
        .config_data  (config_data),
        .config_rdata (config_rdata),
        .O0           (O0),
        .O1           (O1),
`ifdef REGISTER_MODE_PIPE_FILL_EN
        .fill         (fill),
`endif
        .out_valid    (out_valid)
    );

    register_mode_pipe #(.WIDTH(16), .DEPTH(5), .INIT(16'h0000)) dut_b (
        .CLK          (CLK),
        .ASYNCRESETN  (ASYNCRESETN),
        .mode         (mode),
        .const_       (const_),
        .value        (value),
        .value_valid  (value_valid),
        .clk_en       (clk_en),
        .flush        (flush),
        .config_we    (we_b),
        .config_addr  (addr_b),
        .config_data  (config_data),
        .config_rdata (rdata_b),
        .O0           (O0_b),
        .O1           (O1_b),
`ifdef REGISTER_MODE_PIPE_FILL_EN
        .fill         (fill_b),
`endif
        .out_valid    (out_valid_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Reset state in PIPE mode
        #1;
        chk("rst_O0", O0, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_O1", O1, 0);
        chk("rst_rdata", config_rdata, 0);
`ifdef REGISTER_MODE_PIPE_FILL_EN
        chk("rst_fill", fill, 0);
`endif
        step();
        ASYNCRESETN = 1'b1;

        // Out-of-range write on the DEPTH=5 instance is dropped
        we_b = 1'b1; addr_b = 3'd7; config_data = 16'hDEAD;
        step();
        we_b = 1'b0;
        chk("oor_rdata", rdata_b, 0);
        for (int a = 0; a < 5; a++) begin
            addr_b = 3'(a);
            #1;
            chk($sformatf("oor_stage%0d", a), rdata_b, 0);
        end
        chk("oor_valid", out_valid_b, 0);
        we_b = 1'b1; addr_b = 3'd4; config_data = 16'hCAFE;
        step();
        we_b = 1'b0;
        chk("last_stage_wr_O0", O0_b, 16'hCAFE);
        chk("last_stage_wr_valid", out_valid_b, 1);

        // PIPE: 1..5 in, DEPTH=4 edges of latency
        mode = 2'd3; clk_en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            value = (k <= 5) ? 16'(k) : 16'h0;
            value_valid = (k <= 5);
            step();
            if (k >= 4) begin
                chk($sformatf("pipe_O0_e%0d", k), O0, k - 3);
                chk($sformatf("pipe_v_e%0d", k), out_valid, 1);
            end else begin
                chk($sformatf("pipe_v_e%0d", k), out_valid, 0);
            end
`ifdef REGISTER_MODE_PIPE_FILL_EN
            if (k == 3) chk("fill3", fill, 3);
`endif
        end
        clk_en = 1'b0; value = 16'h9999; value_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("hold_O0", O0, 5);
            chk("hold_valid", out_valid, 1);
            chk("hold_O1", O1, 0);
        end

        // DELAY then CONST then BYPASS
        mode = 2'd1; value = 16'hA5A5; value_valid = 1'b1; clk_en = 1'b1;
        step();
        chk("delay_O0", O0, 16'hA5A5);
        chk("delay_O1", O1, 16'hA5A5);
        chk("delay_valid", out_valid, 1);
        mode = 2'd0; const_ = 16'h1234; value = 16'h7777;
        #1;
        chk("const_O0", O0, 16'h1234);
        chk("const_valid", out_valid, 1);
        step();
        chk("const_O1_held", O1, 16'hA5A5);
        mode = 2'd2; value = 16'h5555; value_valid = 1'b0;
        #1;
        chk("bypass_O0", O0, 16'h5555);
        chk("bypass_v0", out_valid, 0);
        value_valid = 1'b1;
        #1;
        chk("bypass_v1", out_valid, 1);

        // Config write + flush + clk_en together in PIPE: s=[A5A5,0,0,5] v=1001
        mode = 2'd3; config_we = 1'b1; config_addr = 2'd2; config_data = 16'hBEEF;
        flush = 1'b1; clk_en = 1'b1; value = 16'h1111; value_valid = 1'b1;
        step();
        config_we = 1'b0; flush = 1'b0; value = 16'h0; value_valid = 1'b0;
        chk("cfg_noshift_O1", O1, 16'hA5A5);
        chk("cfg_O0_retained", O0, 5);
        chk("cfg_valid_cleared", out_valid, 0);
        chk("cfg_rdata", config_rdata, 16'hBEEF);
`ifdef REGISTER_MODE_PIPE_FILL_EN
        chk("cfg_fill", fill, 1);
`endif
        step();
        chk("cfg_shift_O0", O0, 16'hBEEF);
        chk("cfg_shift_valid", out_valid, 1);
        step();
        chk("cfg_drain_valid", out_valid, 0);

        // Plain flush: valid cleared, data kept, no shift
        config_addr = 2'd0; value = 16'h0042; value_valid = 1'b1;
        step();
        flush = 1'b1; value = 16'h0077;
        step();
        flush = 1'b0; clk_en = 1'b0;
        chk("flush_O1", O1, 16'h0042);
        chk("flush_rdata", config_rdata, 16'h0042);
`ifdef REGISTER_MODE_PIPE_FILL_EN
        chk("flush_fill", fill, 0);
`endif

        // Asynchronous reset between edges, then refill
        clk_en = 1'b1; value = 16'h0007; value_valid = 1'b1;
        step();
        step();
        #2 ASYNCRESETN = 1'b0;
        #1;
        chk("arst_O1", O1, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_rdata", config_rdata, 0);
        #1 ASYNCRESETN = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            value = 16'(8 + k);
            step();
            if (k < 4) chk($sformatf("refill_v_e%0d", k), out_valid, 0);
        end
        chk("refill_O0", O0, 16'h0009);
        chk("refill_valid", out_valid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
